// File: rtl/pipe_ctrl_stages.sv
// MIPS pipelined control path: ID decode plus ID/EX, EX/MEM, MEM/WB control registers.
// Supports bne/jal/jr, illegal detection and branch resolution in ID or EX.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic       alusrc;
    logic [2:0] alu;
    logic       branch;
    logic       is_bne;
  } id_ex_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] memtoreg;
  } ex_mem_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] memtoreg;
  } mem_wb_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    regwrite: 1'b0, memwrite: 1'b0,
    memtoreg: 2'b00, regdst: 2'b00,
    alusrc: 1'b0, alu: ALU_ADD,
    branch: 1'b0, is_bne: 1'b0
  };

endpackage

module pipe_ctrl_stages
  import pipe_ctrl_pkg::*;
#(
  parameter bit BRANCH_IN_D = 1'b1,
  parameter int ALUCTL_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode_d,
  input  logic [5:0]          funct_d,
  input  logic                eq_d,
  input  logic                zero_e,
  input  logic                stall_d,
  input  logic                flush_e,
  output logic                pcsrc,
  output logic                jump_d,
  output logic                jump_r_d,
  output logic                flush_f_o,
  output logic                illegal_d,
  output logic [ALUCTL_W-1:0] alucontrol_e,
  output logic                alusrc_e,
  output logic [1:0]          regdst_e,
  output logic                memwrite_m,
  output logic                regwrite_e,
  output logic                regwrite_m,
  output logic                regwrite_w,
  output logic [1:0]          memtoreg_e,
  output logic [1:0]          memtoreg_m,
  output logic [1:0]          memtoreg_w
);

  id_ex_t  dec;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  logic    pcsrc_d;
  logic    pcsrc_e;
  logic    ex_kill;

  always_comb begin
    dec       = ID_EX_BUBBLE;
    jump_d    = 1'b0;
    jump_r_d  = 1'b0;
    illegal_d = 1'b0;
    unique case (opcode_d)
      OP_R: begin
        unique case (funct_d)
          FN_ADD: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 2'b01;
            dec.alu      = ALU_ADD;
          end
          FN_SUB: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 2'b01;
            dec.alu      = ALU_SUB;
          end
          FN_AND: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 2'b01;
            dec.alu      = ALU_AND;
          end
          FN_OR: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 2'b01;
            dec.alu      = ALU_OR;
          end
          FN_SLT: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 2'b01;
            dec.alu      = ALU_SLT;
          end
          FN_JR:   jump_r_d  = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 2'b01;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu    = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch = 1'b1;
        dec.is_bne = 1'b1;
        dec.alu    = ALU_SUB;
      end
      OP_ADDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_J: jump_d = 1'b1;
      OP_JAL: begin
        jump_d       = 1'b1;
        dec.regdst   = 2'b10;
        dec.memtoreg = 2'b10;
        dec.regwrite = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // ID-side operands are not forwarded yet while stalled, so no redirect then
  assign pcsrc_d = dec.branch & (eq_d ^ dec.is_bne) & ~stall_d;
  assign pcsrc_e = id_ex.branch & (zero_e ^ id_ex.is_bne);
  assign ex_kill = ~BRANCH_IN_D & pcsrc_e;

  assign pcsrc = BRANCH_IN_D ? pcsrc_d : pcsrc_e;
  assign flush_f_o = BRANCH_IN_D
                   ? (~stall_d & (pcsrc_d | jump_d | jump_r_d))
                   : (pcsrc_e | jump_d | jump_r_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex <= ID_EX_BUBBLE;
    end else if (flush_e | ex_kill) begin
      id_ex <= ID_EX_BUBBLE;
    end else if (!stall_d) begin
      id_ex <= dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem <= '{
        regwrite: id_ex.regwrite,
        memwrite: id_ex.memwrite,
        memtoreg: id_ex.memtoreg
      };
      mem_wb <= '{
        regwrite: ex_mem.regwrite,
        memtoreg: ex_mem.memtoreg
      };
    end
  end

  assign alucontrol_e = ALUCTL_W'(id_ex.alu);
  assign alusrc_e     = id_ex.alusrc;
  assign regdst_e     = id_ex.regdst;
  assign regwrite_e   = id_ex.regwrite;
  assign memtoreg_e   = id_ex.memtoreg;
  assign memwrite_m   = ex_mem.memwrite;
  assign regwrite_m   = ex_mem.regwrite;
  assign memtoreg_m   = ex_mem.memtoreg;
  assign regwrite_w   = mem_wb.regwrite;
  assign memtoreg_w   = mem_wb.memtoreg;

endmodule

// File: tb/tb_pipe_ctrl_stages.sv
// Bench for pipe_ctrl_stages: ID-resolved and EX-resolved instances share stimulus,
// checked each cycle against a stage-list model plus literal expectations.
module tb_pipe_ctrl_stages;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] mtr;
    logic [1:0] rd;
    logic       asrc;
    logic [2:0] alu;
    logic       br;
    logic       bne;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_d = ADDI;
  logic [5:0] funct_d = 6'd0;
  logic       eq_d = 1'b0;
  logic       zero_e = 1'b0;
  logic       stall_d = 1'b0;
  logic       flush_e = 1'b0;
  logic       run = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       dd_pcsrc, dd_jump_d, dd_jump_r_d, dd_flush_f_o, dd_illegal_d;
  logic [2:0] dd_alucontrol_e;
  logic       dd_alusrc_e, dd_memwrite_m;
  logic [1:0] dd_regdst_e;
  logic       dd_regwrite_e, dd_regwrite_m, dd_regwrite_w;
  logic [1:0] dd_memtoreg_e, dd_memtoreg_m, dd_memtoreg_w;

  logic       de_pcsrc, de_jump_d, de_jump_r_d, de_flush_f_o, de_illegal_d;
  logic [3:0] de_alucontrol_e;
  logic       de_alusrc_e, de_memwrite_m;
  logic [1:0] de_regdst_e;
  logic       de_regwrite_e, de_regwrite_m, de_regwrite_w;
  logic [1:0] de_memtoreg_e, de_memtoreg_m, de_memtoreg_w;

  always #5 clk = ~clk;

  pipe_ctrl_stages #(.BRANCH_IN_D(1'b1), .ALUCTL_W(3)) dut_d (
    .clk(clk), .reset(reset),
    .opcode_d(opcode_d), .funct_d(funct_d),
    .eq_d(eq_d), .zero_e(zero_e),
    .stall_d(stall_d), .flush_e(flush_e),
    .pcsrc(dd_pcsrc), .jump_d(dd_jump_d),
    .jump_r_d(dd_jump_r_d), .flush_f_o(dd_flush_f_o),
    .illegal_d(dd_illegal_d),
    .alucontrol_e(dd_alucontrol_e),
    .alusrc_e(dd_alusrc_e), .regdst_e(dd_regdst_e),
    .memwrite_m(dd_memwrite_m),
    .regwrite_e(dd_regwrite_e), .regwrite_m(dd_regwrite_m),
    .regwrite_w(dd_regwrite_w),
    .memtoreg_e(dd_memtoreg_e), .memtoreg_m(dd_memtoreg_m),
    .memtoreg_w(dd_memtoreg_w)
  );

  pipe_ctrl_stages #(.BRANCH_IN_D(1'b0), .ALUCTL_W(4)) dut_e (
    .clk(clk), .reset(reset),
    .opcode_d(opcode_d), .funct_d(funct_d),
    .eq_d(eq_d), .zero_e(zero_e),
    .stall_d(stall_d), .flush_e(flush_e),
    .pcsrc(de_pcsrc), .jump_d(de_jump_d),
    .jump_r_d(de_jump_r_d), .flush_f_o(de_flush_f_o),
    .illegal_d(de_illegal_d),
    .alucontrol_e(de_alucontrol_e),
    .alusrc_e(de_alusrc_e), .regdst_e(de_regdst_e),
    .memwrite_m(de_memwrite_m),
    .regwrite_e(de_regwrite_e), .regwrite_m(de_regwrite_m),
    .regwrite_w(de_regwrite_w),
    .memtoreg_e(de_memtoreg_e), .memtoreg_m(de_memtoreg_m),
    .memtoreg_w(de_memtoreg_w)
  );

  function automatic ctl_t bubble();
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    return c;
  endfunction

  function automatic ctl_t spec_dec(
    input logic [5:0] op, input logic [5:0] fn,
    output bit j, output bit jr, output bit ill
  );
    ctl_t c;
    c = bubble();
    j = 0;
    jr = 0;
    ill = 0;
    if (op == R) begin
      if (fn == F_ADD || fn == F_SUB || fn == F_AND ||
          fn == F_OR || fn == F_SLT) begin
        c.rw = 1'b1;
        c.rd = 2'b01;
        if (fn == F_SUB) c.alu = 3'b110;
        if (fn == F_AND) c.alu = 3'b000;
        if (fn == F_OR)  c.alu = 3'b001;
        if (fn == F_SLT) c.alu = 3'b111;
      end else if (fn == F_JR) jr = 1;
      else ill = 1;
    end else if (op == LW) begin
      c.asrc = 1'b1; c.rw = 1'b1; c.mtr = 2'b01;
    end else if (op == SW) begin
      c.asrc = 1'b1; c.mw = 1'b1;
    end else if (op == BEQ || op == BNE) begin
      c.br = 1'b1; c.alu = 3'b110; c.bne = (op == BNE);
    end else if (op == ADDI) begin
      c.asrc = 1'b1; c.rw = 1'b1;
    end else if (op == J) begin
      j = 1;
    end else if (op == JAL) begin
      j = 1; c.rd = 2'b10; c.mtr = 2'b10; c.rw = 1'b1;
    end else ill = 1;
    return c;
  endfunction

  // stage contents: index 0 = EX-resolved instance, 1 = ID-resolved
  ctl_t ex_q [2];
  ctl_t mem_q[2];
  ctl_t wb_q [2];

  function automatic logic taken_e();
    return ex_q[0].br && (zero_e != ex_q[0].bne);
  endfunction

  function automatic ctl_t next_ex(input int m);
    ctl_t d;
    bit j, jr, ill;
    d = spec_dec(opcode_d, funct_d, j, jr, ill);
    if (flush_e || (m == 0 && taken_e())) return bubble();
    if (stall_d) return ex_q[m];
    return d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q[0]  <= bubble();
      ex_q[1]  <= bubble();
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wb_q[0]  <= '0;
      wb_q[1]  <= '0;
    end else begin
      ex_q[0]  <= next_ex(0);
      ex_q[1]  <= next_ex(1);
      mem_q[0] <= ex_q[0];
      mem_q[1] <= ex_q[1];
      wb_q[0]  <= mem_q[0];
      wb_q[1]  <= mem_q[1];
    end
  end

  function automatic logic [21:0] expect_vec(input int m);
    ctl_t d;
    bit j, jr, ill, pc, fl;
    d = spec_dec(opcode_d, funct_d, j, jr, ill);
    if (m == 1) begin
      pc = d.br && (eq_d != d.bne) && !stall_d;
      fl = !stall_d && (pc || j || jr);
    end else begin
      pc = taken_e();
      fl = pc || j || jr;
    end
    return {pc, j, jr, fl, ill, 1'b0, ex_q[m].alu,
            ex_q[m].asrc, ex_q[m].rd, mem_q[m].mw,
            ex_q[m].rw, mem_q[m].rw, wb_q[m].rw,
            ex_q[m].mtr, mem_q[m].mtr, wb_q[m].mtr};
  endfunction

  task automatic cmp(input string n, input logic [21:0] act,
                     input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", n, $time, act, exp);
    end
  endtask

  task automatic lit(input string n, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp("pipe_id", {dd_pcsrc, dd_jump_d, dd_jump_r_d, dd_flush_f_o,
                      dd_illegal_d, 1'b0, dd_alucontrol_e, dd_alusrc_e,
                      dd_regdst_e, dd_memwrite_m, dd_regwrite_e,
                      dd_regwrite_m, dd_regwrite_w, dd_memtoreg_e,
                      dd_memtoreg_m, dd_memtoreg_w}, expect_vec(1));
      cmp("pipe_ex", {de_pcsrc, de_jump_d, de_jump_r_d, de_flush_f_o,
                      de_illegal_d, de_alucontrol_e, de_alusrc_e,
                      de_regdst_e, de_memwrite_m, de_regwrite_e,
                      de_regwrite_m, de_regwrite_w, de_memtoreg_e,
                      de_memtoreg_m, de_memtoreg_w}, expect_vec(0));
    end
  end

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic z,
                        input logic st, input logic fl);
    opcode_d = op;
    funct_d  = fn;
    eq_d     = eq;
    zero_e   = z;
    stall_d  = st;
    flush_e  = fl;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [12] = '{R, LW, BNE, SW, R, ADDI,
                           BEQ, JAL, R, J, 6'h3F, R};
  logic [5:0] fns [12] = '{F_SUB, 6'd0, 6'd0, 6'd0, F_AND, 6'd0,
                           6'd0, 6'd0, F_OR, 6'd0, 6'd0, F_SLT};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("rst_alu_id", 4'(dd_alucontrol_e), 4'd2);
    lit("rst_alu_ex", de_alucontrol_e, 4'd2);
    lit("rst_rw_w", 4'(dd_regwrite_w), 4'd0);
    lit("rst_mtr_m", 4'(dd_memtoreg_m), 4'd0);
    reset = 1'b0;
    run = 1'b1;

    set_in(R, F_ADD, 0, 0, 0, 0);
    clk1();
    lit("add_rw_e", 4'(dd_regwrite_e), 4'd1);
    lit("add_rd_e", 4'(dd_regdst_e), 4'd1);
    lit("add_alu_e", 4'(dd_alucontrol_e), 4'd2);
    set_in(SW, 6'd0, 0, 0, 0, 0);
    clk1();
    lit("add_rw_m", 4'(dd_regwrite_m), 4'd1);
    lit("sw_asrc_e", 4'(dd_alusrc_e), 4'd1);
    lit("sw_rw_e", 4'(dd_regwrite_e), 4'd0);
    set_in(ADDI, 6'd0, 0, 0, 0, 0);
    clk1();
    lit("add_rw_w", 4'(dd_regwrite_w), 4'd1);
    lit("add_mtr_w", 4'(dd_memtoreg_w), 4'd0);
    lit("sw_mw_m", 4'(dd_memwrite_m), 4'd1);

    set_in(LW, 6'd0, 0, 0, 0, 0);
    clk1();
    lit("lw_mtr_e", 4'(dd_memtoreg_e), 4'd1);
    set_in(ADDI, 6'd0, 0, 0, 1, 0);
    clk1();
    lit("stall_hold_mtr", 4'(dd_memtoreg_e), 4'd1);
    lit("stall_lw_m", 4'(dd_memtoreg_m), 4'd1);
    set_in(ADDI, 6'd0, 0, 0, 1, 1);
    clk1();
    lit("flush_rw_e", 4'(dd_regwrite_e), 4'd0);
    lit("flush_mtr_e", 4'(dd_memtoreg_e), 4'd0);
    lit("flush_alu_e", 4'(dd_alucontrol_e), 4'd2);

    set_in(BNE, 6'd0, 0, 0, 0, 0);
    #1;
    lit("bne_pcsrc", 4'(dd_pcsrc), 4'd1);
    lit("bne_flush_f", 4'(dd_flush_f_o), 4'd1);
    stall_d = 1'b1;
    #1;
    lit("bne_stall_pc", 4'(dd_pcsrc), 4'd0);
    lit("bne_stall_ff", 4'(dd_flush_f_o), 4'd0);
    clk1();
    set_in(BEQ, 6'd0, 0, 0, 0, 0);
    #1;
    lit("beq_ne_pc", 4'(dd_pcsrc), 4'd0);
    clk1();

    set_in(BEQ, 6'd0, 0, 0, 0, 0);
    clk1();
    set_in(ADDI, 6'd0, 0, 1, 0, 0);
    #1;
    lit("exbr_pcsrc", 4'(de_pcsrc), 4'd1);
    lit("exbr_flush_f", 4'(de_flush_f_o), 4'd1);
    clk1();
    lit("exkill_rw_e", 4'(de_regwrite_e), 4'd0);
    lit("exkill_alu_e", de_alucontrol_e, 4'd2);
    lit("idmode_addi", 4'(dd_regwrite_e), 4'd1);

    set_in(JAL, 6'd0, 0, 0, 0, 0);
    #1;
    lit("jal_jump", 4'(dd_jump_d), 4'd1);
    lit("jal_flush_f", 4'(dd_flush_f_o), 4'd1);
    clk1();
    lit("jal_rd_e", 4'(dd_regdst_e), 4'd2);
    set_in(R, F_JR, 0, 0, 0, 0);
    #1;
    lit("jr_jump_r", 4'(dd_jump_r_d), 4'd1);
    clk1();
    lit("jr_rw_e", 4'(dd_regwrite_e), 4'd0);
    set_in(ADDI, 6'd0, 0, 0, 0, 0);
    clk1();
    lit("jal_rw_w", 4'(dd_regwrite_w), 4'd1);
    lit("jal_mtr_w", 4'(dd_memtoreg_w), 4'd2);

    set_in(6'h3F, 6'd0, 0, 0, 0, 0);
    #1;
    lit("ill_flag", 4'(dd_illegal_d), 4'd1);
    lit("ill_jump", 4'(dd_jump_d), 4'd0);
    repeat (3) clk1();
    lit("ill_rw_e", 4'(dd_regwrite_e), 4'd0);
    lit("ill_rw_m", 4'(dd_regwrite_m), 4'd0);
    lit("ill_mw_m", 4'(dd_memwrite_m), 4'd0);
    lit("ill_rw_w", 4'(dd_regwrite_w), 4'd0);

    for (int i = 0; i < 36; i++) begin
      set_in(ops[i % 12], fns[i % 12], (i % 3) == 0, (i % 4) == 1,
             (i % 5) == 2, (i % 7) == 3);
      clk1();
    end

    set_in(LW, 6'd0, 0, 0, 0, 0);
    clk1();
    set_in(R, F_ADD, 0, 0, 0, 0);
    clk1();
    #2;
    reset = 1'b1;
    #1;
    lit("arst_rw_e", 4'(dd_regwrite_e), 4'd0);
    lit("arst_rw_m", 4'(dd_regwrite_m), 4'd0);
    lit("arst_mtr_m", 4'(dd_memtoreg_m), 4'd0);
    lit("arst_alu_e", 4'(dd_alucontrol_e), 4'd2);
    lit("arst_rw_m_ex", 4'(de_regwrite_m), 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(ADDI, 6'd0, 0, 0, 0, 0);
    repeat (2) clk1();
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
